// File: rtl/dpram_be.sv
// True dual-port byte-strobed RAM, one clock, registered read data with valid flags.
// Define DPRAM_BE_PARITY_EN to store and check one even-parity bit per byte.
module dpram_be #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 14,
    parameter int DEPTH      = 16384,
    parameter int WRITE_MODE = 0,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [DATA_W/8-1:0]   wea,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [DATA_W-1:0]     dina,
    output logic [DATA_W-1:0]     douta,
    output logic                  vala,
    output logic [DATA_W/8-1:0]   perra,
    input  logic                  enb,
    input  logic [DATA_W/8-1:0]   web,
    input  logic [ADDR_W-1:0]     addrb,
    input  logic [DATA_W-1:0]     dinb,
    output logic [DATA_W-1:0]     doutb,
    output logic                  valb,
    output logic [DATA_W/8-1:0]   perrb,
    output logic                  coll
);
    localparam int                NB       = DATA_W / 8;
    localparam int                IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam bit                RD_ON_WR = (WRITE_MODE == 1);

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef DPRAM_BE_PARITY_EN
    logic [NB-1:0]     par [DEPTH];

    function automatic logic [NB-1:0] par_gen(input logic [DATA_W-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction
`endif

    // rst_q stays high for the edge at which rst deasserts, so that edge is ignored too
    logic rst_q;
    logic live;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_q <= 1'b1;
        else     rst_q <= 1'b0;
    end
    assign live = ~rst & ~rst_q;

    // ---- stage p0: request decode ----
    logic [1:0]             en_p0, rd_p0, wr_p0, inr_p0;
    logic [1:0][NB-1:0]     we_p0;
    logic [1:0][ADDR_W-1:0] addr_p0;
    logic [1:0][DATA_W-1:0] din_p0;
    logic [1:0][IW-1:0]     idx_p0;
    logic                   same_p0;

    assign en_p0   = {enb, ena};
    assign we_p0   = {web, wea};
    assign addr_p0 = {addrb, addra};
    assign din_p0  = {dinb, dina};
    assign same_p0 = (addra == addrb);

    // Overlapping lanes on the same word go to port A
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_p0[1] && we_p0[1][i] && !(wr_p0[0] && we_p0[0][i] && same_p0)) begin
                mem[idx_p0[1]][8*i +: 8] <= din_p0[1][8*i +: 8];
`ifdef DPRAM_BE_PARITY_EN
                par[idx_p0[1]][i] <= ^din_p0[1][8*i +: 8];
`endif
            end
            if (wr_p0[0] && we_p0[0][i]) begin
                mem[idx_p0[0]][8*i +: 8] <= din_p0[0][8*i +: 8];
`ifdef DPRAM_BE_PARITY_EN
                par[idx_p0[0]][i] <= ^din_p0[0][8*i +: 8];
`endif
            end
        end
    end

    // ---- stage p1: registered read data, valid, parity check ----
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_W-1:0] dout_p1;
        logic              vld_p1;
`ifdef DPRAM_BE_PARITY_EN
        logic [NB-1:0]     perr_p1;
`endif

        assign inr_p0[p] = ({1'b0, addr_p0[p]} < DEPTH_V);
        assign idx_p0[p] = addr_p0[p][IW-1:0];
        assign rd_p0[p]  = live & en_p0[p] & (~|we_p0[p] | RD_ON_WR);
        assign wr_p0[p]  = live & en_p0[p] & inr_p0[p] & (|we_p0[p]);

        // Reads sample the pre-edge word, giving read-before-write on collisions
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_p1 <= '0;
                vld_p1  <= 1'b0;
`ifdef DPRAM_BE_PARITY_EN
                perr_p1 <= '0;
`endif
            end else begin
                vld_p1 <= rd_p0[p];
`ifdef DPRAM_BE_PARITY_EN
                perr_p1 <= '0;
`endif
                if (rd_p0[p]) begin
                    if (inr_p0[p]) begin
                        dout_p1 <= mem[idx_p0[p]];
`ifdef DPRAM_BE_PARITY_EN
                        perr_p1 <= par_gen(mem[idx_p0[p]]) ^ par[idx_p0[p]];
`endif
                    end else begin
                        dout_p1 <= '0;
                    end
                end
            end
        end
    end

    logic coll_p1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) coll_p1 <= 1'b0;
        else     coll_p1 <= live & ena & enb & same_p0 & (|(wea | web));
    end

    assign douta = g_port[0].dout_p1;
    assign vala  = g_port[0].vld_p1;
    assign doutb = g_port[1].dout_p1;
    assign valb  = g_port[1].vld_p1;
    assign coll  = coll_p1;
`ifdef DPRAM_BE_PARITY_EN
    assign perra = g_port[0].perr_p1;
    assign perrb = g_port[1].perr_p1;
`else
    assign perra = '0;
    assign perrb = '0;
`endif

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: one NO_CHANGE and one READ_FIRST instance driven in parallel
// against a word-array reference model, directed scenarios plus random traffic.
module tb_dpram_be;
    localparam int AW = 6;
    localparam int DEPTH = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ena, enb;
    logic [3:0]  wea, web;
    logic [AW-1:0] addra, addrb;
    logic [31:0] dina, dinb;

    logic [31:0] douta_m [2];
    logic [31:0] doutb_m [2];
    logic        vala_m  [2];
    logic        valb_m  [2];
    logic [3:0]  perra_m [2];
    logic [3:0]  perrb_m [2];
    logic        coll_m  [2];

    dpram_be #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .WRITE_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_m[0]), .vala(vala_m[0]), .perra(perra_m[0]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
        .doutb(doutb_m[0]), .valb(valb_m[0]), .perrb(perrb_m[0]),
        .coll(coll_m[0]));

    dpram_be #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .WRITE_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_m[1]), .vala(vala_m[1]), .perra(perra_m[1]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
        .doutb(doutb_m[1]), .valb(valb_m[1]), .perrb(perrb_m[1]),
        .coll(coll_m[1]));

    // Reference model: memory words and expected outputs per instance (index = WRITE_MODE)
    logic [31:0] mmem [DEPTH];
    logic [31:0] e_da [2];
    logic [31:0] e_db [2];
    logic        e_va [2];
    logic        e_vb [2];
    logic        e_coll;
    bit          ign;
    int          total, bad;
    string       tag;

    task automatic drive(input logic ea, input logic [3:0] wa, input logic [AW-1:0] aa,
                         input logic [31:0] da, input logic eb, input logic [3:0] wb,
                         input logic [AW-1:0] ab, input logic [31:0] db);
        ena = ea; wea = wa; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    endtask

    // Advance one clock, updating the model from the current request
    task automatic step();
        for (int m = 0; m < 2; m++) begin
            e_va[m] = 1'b0;
            e_vb[m] = 1'b0;
            if (!ign && ena && (wea == 4'h0 || m == 1)) begin
                e_va[m] = 1'b1;
                if (int'(addra) < DEPTH) e_da[m] = mmem[addra];
                else                     e_da[m] = 32'h0;
            end
            if (!ign && enb && (web == 4'h0 || m == 1)) begin
                e_vb[m] = 1'b1;
                if (int'(addrb) < DEPTH) e_db[m] = mmem[addrb];
                else                     e_db[m] = 32'h0;
            end
        end
        e_coll = !ign && ena && enb && (addra == addrb) && ((wea | web) != 4'h0);
        if (!ign) begin
            for (int i = 0; i < 4; i++)
                if (enb && int'(addrb) < DEPTH && web[i]) mmem[addrb][8*i +: 8] = dinb[8*i +: 8];
            for (int i = 0; i < 4; i++)
                if (ena && int'(addra) < DEPTH && wea[i]) mmem[addra][8*i +: 8] = dina[8*i +: 8];
        end
        @(posedge clk);
        #1;
        ign = 1'b0;
    endtask

    task automatic test_reset();
        tag = "reset";
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            e_da[m] = 32'h0; e_db[m] = 32'h0; e_va[m] = 1'b0; e_vb[m] = 1'b0;
            if (douta_m[m] !== 32'h0) begin bad++; $display("FAIL %s douta m%0d got %h want 0", tag, m, douta_m[m]); end
            total++;
            if (doutb_m[m] !== 32'h0) begin bad++; $display("FAIL %s doutb m%0d got %h want 0", tag, m, doutb_m[m]); end
            total++;
            if ({vala_m[m], valb_m[m], coll_m[m]} !== 3'b000) begin
                bad++; $display("FAIL %s val/coll m%0d got %b want 000", tag, m, {vala_m[m], valb_m[m], coll_m[m]});
            end
            total++;
            if ({perra_m[m], perrb_m[m]} !== 8'h0) begin
                bad++; $display("FAIL %s perr m%0d got %h want 0", tag, m, {perra_m[m], perrb_m[m]});
            end
            total++;
        end
        e_coll = 1'b0;
        rst = 1'b0;
        ign = 1'b1;
        drive(1'b1, 4'h0, 6'd2, 32'h0, 1'b1, 4'hF, 6'd2, 32'h55);
        step();
        for (int m = 0; m < 2; m++) begin
            if ({vala_m[m], valb_m[m], coll_m[m]} !== 3'b000) begin
                bad++; $display("FAIL %s release-edge m%0d got %b want 000", tag, m, {vala_m[m], valb_m[m], coll_m[m]});
            end
            total++;
        end
    endtask

    task automatic test_init();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, 4'hF, 6'(a), $urandom, 1'b0, 4'h0, 6'd0, 32'h0);
            step();
        end
        idle();
        step();
    endtask

    task automatic test_bytelane();
        tag = "bytelane";
        drive(1'b1, 4'hF, 6'd3, 32'h11223344, 1'b0, 4'h0, 6'd0, 32'h0);
        step();
        drive(1'b1, 4'b0101, 6'd3, 32'hAABBCCDD, 1'b0, 4'h0, 6'd0, 32'h0);
        step();
        if (vala_m[0] !== 1'b0) begin bad++; $display("FAIL %s nochange vala got %b want 0", tag, vala_m[0]); end
        total++;
        if (douta_m[1] !== 32'h11223344 || vala_m[1] !== 1'b1) begin
            bad++; $display("FAIL %s readfirst douta got %h/%b want 11223344/1", tag, douta_m[1], vala_m[1]);
        end
        total++;
        drive(1'b1, 4'h0, 6'd3, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
        step();
        for (int m = 0; m < 2; m++) begin
            if (douta_m[m] !== 32'h11BB33DD || vala_m[m] !== 1'b1) begin
                bad++; $display("FAIL %s readback m%0d got %h/%b want 11BB33DD/1", tag, m, douta_m[m], vala_m[m]);
            end
            total++;
        end
    endtask

    task automatic test_collision();
        tag = "collision";
        drive(1'b1, 4'hF, 6'd7, 32'h99887766, 1'b1, 4'hF, 6'd9, 32'h1);
        step();
        drive(1'b1, 4'b0011, 6'd7, 32'h0000AAAA, 1'b1, 4'b0110, 6'd7, 32'h00BBBB00);
        step();
        if (coll_m[0] !== 1'b1) begin bad++; $display("FAIL %s ww coll got %b want 1", tag, coll_m[0]); end
        total++;
        drive(1'b1, 4'h0, 6'd7, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
        step();
        if (coll_m[0] !== 1'b0) begin bad++; $display("FAIL %s coll pulse got %b want 0", tag, coll_m[0]); end
        total++;
        if (douta_m[0] !== 32'h99BBAAAA) begin bad++; $display("FAIL %s ww word got %h want 99BBAAAA", tag, douta_m[0]); end
        total++;
        drive(1'b1, 4'h0, 6'd9, 32'h0, 1'b1, 4'hF, 6'd9, 32'h2);
        step();
        for (int m = 0; m < 2; m++) begin
            if (douta_m[m] !== 32'h1 || coll_m[m] !== 1'b1) begin
                bad++; $display("FAIL %s rw m%0d got %h/%b want 1/1", tag, m, douta_m[m], coll_m[m]);
            end
            total++;
        end
        drive(1'b1, 4'h0, 6'd9, 32'h0, 1'b1, 4'h0, 6'd9, 32'h0);
        step();
        for (int m = 0; m < 2; m++) begin
            if (douta_m[m] !== 32'h2 || doutb_m[m] !== 32'h2 || coll_m[m] !== 1'b0) begin
                bad++; $display("FAIL %s rr m%0d got %h/%h/%b want 2/2/0", tag, m, douta_m[m], doutb_m[m], coll_m[m]);
            end
            total++;
        end
    endtask

    task automatic test_write_mode();
        logic [31:0] prev;
        tag = "write_mode";
        drive(1'b1, 4'hF, 6'd0, 32'h4, 1'b1, 4'hF, 6'd1, 32'h0BADF00D);
        step();
        drive(1'b1, 4'h0, 6'd1, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
        step();
        prev = 32'h0BADF00D;
        drive(1'b1, 4'hF, 6'd0, 32'h5, 1'b0, 4'h0, 6'd0, 32'h0);
        step();
        if (douta_m[0] !== prev || vala_m[0] !== 1'b0) begin
            bad++; $display("FAIL %s nochange got %h/%b want %h/0", tag, douta_m[0], vala_m[0], prev);
        end
        total++;
        if (douta_m[1] !== 32'h4 || vala_m[1] !== 1'b1) begin
            bad++; $display("FAIL %s readfirst got %h/%b want 4/1", tag, douta_m[1], vala_m[1]);
        end
        total++;
        idle();
        step();
        if (vala_m[1] !== 1'b0 || douta_m[1] !== 32'h4) begin
            bad++; $display("FAIL %s idle hold got %h/%b want 4/0", tag, douta_m[1], vala_m[1]);
        end
        total++;
    endtask

    task automatic test_out_of_range();
        tag = "out_of_range";
        drive(1'b1, 4'hF, 6'd48, 32'hFFFFFFFF, 1'b1, 4'h0, 6'd63, 32'h0);
        step();
        for (int m = 0; m < 2; m++) begin
            if (doutb_m[m] !== 32'h0 || valb_m[m] !== 1'b1 || perrb_m[m] !== 4'h0) begin
                bad++; $display("FAIL %s rd63 m%0d got %h/%b want 0/1", tag, m, doutb_m[m], valb_m[m]);
            end
            total++;
            if (vala_m[m] !== e_va[m] || douta_m[m] !== e_da[m]) begin
                bad++; $display("FAIL %s wr48 m%0d got %h/%b want %h/%b", tag, m, douta_m[m], vala_m[m], e_da[m], e_va[m]);
            end
            total++;
        end
        drive(1'b1, 4'h0, 6'd48, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
        step();
        for (int m = 0; m < 2; m++) begin
            if (douta_m[m] !== 32'h0 || vala_m[m] !== 1'b1 || perra_m[m] !== 4'h0) begin
                bad++; $display("FAIL %s rd48 m%0d got %h/%b/%h want 0/1/0", tag, m, douta_m[m], vala_m[m], perra_m[m]);
            end
            total++;
        end
    endtask

    task automatic test_rst_midstream();
        tag = "rst_midstream";
        drive(1'b1, 4'hF, 6'd5, 32'hCAFEF00D, 1'b0, 4'h0, 6'd0, 32'h0);
        step();
        drive(1'b1, 4'h0, 6'd5, 32'h0, 1'b1, 4'h0, 6'd6, 32'h0);
        step();
        drive(1'b1, 4'h0, 6'd5, 32'h0, 1'b1, 4'hF, 6'd5, 32'h12345678);
        #2 rst = 1'b1;
        #1;
        if (douta_m[0] !== 32'h0 || vala_m[0] !== 1'b0 || valb_m[1] !== 1'b0) begin
            bad++; $display("FAIL %s async clear got %h/%b/%b want 0/0/0", tag, douta_m[0], vala_m[0], valb_m[1]);
        end
        total++;
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            e_da[m] = 32'h0; e_db[m] = 32'h0; e_va[m] = 1'b0; e_vb[m] = 1'b0;
            if ({douta_m[m], doutb_m[m]} !== 64'h0 || {vala_m[m], valb_m[m], coll_m[m]} !== 3'b000) begin
                bad++; $display("FAIL %s held m%0d got %h/%h/%b want 0", tag, m, douta_m[m], doutb_m[m], {vala_m[m], valb_m[m]});
            end
            total++;
        end
        rst = 1'b0;
        ign = 1'b1;
        step();
        if (vala_m[1] !== 1'b0 || valb_m[1] !== 1'b0 || coll_m[1] !== 1'b0) begin
            bad++; $display("FAIL %s release edge got %b%b%b want 000", tag, vala_m[1], valb_m[1], coll_m[1]);
        end
        total++;
        drive(1'b1, 4'h0, 6'd5, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
        step();
        for (int m = 0; m < 2; m++) begin
            if (douta_m[m] !== 32'hCAFEF00D || vala_m[m] !== 1'b1) begin
                bad++; $display("FAIL %s reread m%0d got %h/%b want CAFEF00D/1", tag, m, douta_m[m], vala_m[m]);
            end
            total++;
        end
    endtask

    task automatic test_random();
        tag = "random";
        for (int n = 0; n < 400; n++) begin
            ena   = 1'($urandom_range(0, 3) != 0);
            enb   = 1'($urandom_range(0, 3) != 0);
            wea   = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            web   = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            addra = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 5));
            addrb = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 5));
            dina  = $urandom;
            dinb  = $urandom;
            step();
            for (int m = 0; m < 2; m++) begin
                if (vala_m[m] !== e_va[m] || douta_m[m] !== e_da[m]) begin
                    bad++; $display("FAIL %s n%0d m%0d porta got %h/%b want %h/%b", tag, n, m, douta_m[m], vala_m[m], e_da[m], e_va[m]);
                end
                total++;
                if (valb_m[m] !== e_vb[m] || doutb_m[m] !== e_db[m]) begin
                    bad++; $display("FAIL %s n%0d m%0d portb got %h/%b want %h/%b", tag, n, m, doutb_m[m], valb_m[m], e_db[m], e_vb[m]);
                end
                total++;
                if (coll_m[m] !== e_coll || perra_m[m] !== 4'h0 || perrb_m[m] !== 4'h0) begin
                    bad++; $display("FAIL %s n%0d m%0d coll/perr got %b/%h/%h want %b/0/0", tag, n, m, coll_m[m], perra_m[m], perrb_m[m], e_coll);
                end
                total++;
            end
        end
    endtask

`ifdef DPRAM_BE_PARITY_EN
    task automatic test_parity();
        tag = "parity";
        drive(1'b1, 4'hF, 6'd11, 32'h0F0F0F0F, 1'b0, 4'h0, 6'd0, 32'h0);
        step();
        idle();
        dut0.mem[11][9] = ~dut0.mem[11][9];
        dut1.mem[11][9] = ~dut1.mem[11][9];
        drive(1'b1, 4'h0, 6'd11, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
        step();
        for (int m = 0; m < 2; m++) begin
            if (perra_m[m] !== 4'b0010 || vala_m[m] !== 1'b1 || douta_m[m] !== 32'h0F0F0D0F) begin
                bad++; $display("FAIL %s m%0d got %h/%b/%h want 2/1/0F0F0D0F", tag, m, perra_m[m], vala_m[m], douta_m[m]);
            end
            total++;
        end
        idle();
        step();
        if (perra_m[0] !== 4'h0) begin bad++; $display("FAIL %s clear got %h want 0", tag, perra_m[0]); end
        total++;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        ign   = 1'b0;
        test_reset();
        test_init();
        test_bytelane();
        test_collision();
        test_write_mode();
        test_out_of_range();
        test_rst_midstream();
        test_random();
`ifdef DPRAM_BE_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
